ddr4_v2_2_24_tg_prbs_seq_ctrl: RTL and testbench
================================================

Name: ddr4_v2_2_24_tg_prbs_seq_ctrl

Overview:
Sequencer for the traffic generator's per-data-bit PRBS datapath. It owns one LFSR per DQ bit and selects each seed from either the default seed table or user-written seed registers. It loads the seeds on command, then steps every LFSR once per accepted beat over a programmed burst length. It can rewind to the burst-start state so the read-check path can regenerate the same expected data.

Parameters:
DATA_WIDTH, 72, number of DQ bits/LFSRs, legal range 1..144
PRBS_WIDTH, 23, LFSR length; only 8, 10 or 23 are legal, any other value is an elaboration error
BURST_CNT_W, 16, width of burst_len and of the beat counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
default_seed  in  DATA_WIDTH*PRBS_WIDTH  flattened default seeds, bit i at [i*PRBS_WIDTH +: PRBS_WIDTH]
use_user_seed  in  1  1 = load from user seed registers, 0 = load from default_seed; sampled with start
seed_wr_en  in  1  user seed register write strobe
seed_wr_idx  in  8  index of the DQ bit whose seed register is written
seed_wr_data  in  PRBS_WIDTH  user seed value
start  in  1  begin a new burst; accepted only in IDLE
burst_len  in  BURST_CNT_W  number of beats in the burst; sampled with start
rewind  in  1  pulse: replay the current burst from its seed
dout_valid  out  1  beat available
dout_ready  in  1  consumer accepts the beat
dout  out  DATA_WIDTH  current beat, one bit per LFSR
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset values: state=IDLE, all LFSRs=0, snapshot=0, user seed registers=0, beat_cnt=0, dout_valid=0, dout=0, busy=0, done=0.
- LFSR update is Fibonacci, shifting left: next = {lfsr[W-2:0], fb}. The output bit is lfsr[W-1].
- Feedback taps:
  - PRBS8: bits 7^5^4^3 (x^8+x^6+x^5+x^4+1).
  - PRBS10: bits 9^6 (x^10+x^7+1).
  - PRBS23: bits 22^17 (x^23+x^18+1).
- Seed sanitise: an all-zero seed is replaced with 1 so an LFSR cannot lock up.
- User seed writes:
  - Accepted only in IDLE; writes in any other state are ignored.
  - seed_wr_idx >= DATA_WIDTH is ignored.
  - A write landing in the same cycle as start is committed before the LOAD state reads the registers.
- State IDLE: start -> LOAD. Latch burst_len and use_user_seed.
- State LOAD (1 cycle):
  - lfsr[i] <= sanitised seed; snapshot[i] <= the same value; beat_cnt <= 0.
  - Next state is RUN, or DONE if the latched burst_len == 0.
- State RUN:
  - dout_valid=1; dout[i]=lfsr[i][W-1], driven from registers only.
  - On dout_valid && dout_ready: step all LFSRs and increment beat_cnt.
  - When the beat with beat_cnt == len-1 is accepted -> DONE.
  - dout and dout_valid hold stable while dout_ready=0.
- State DONE: done=1 for one cycle, dout_valid=0 -> IDLE.
- Latency: start accepted in cycle N -> LOAD in N+1 -> first dout_valid in N+2.
- Rewind:
  - A rewind pulse in RUN or IDLE (IDLE only after at least one burst) sets lfsr <= snapshot and beat_cnt <= 0, and enters RUN with the previously latched burst_len.
  - Rewind in the same cycle as an accepted beat: rewind wins and the step is not applied.
  - Rewind in LOAD or DONE is ignored.
- start outside IDLE is ignored. start and rewind together in IDLE: start wins.
- beat_cnt never wraps, because len is at most 2^BURST_CNT_W-1.
- rst_n asserted mid-burst: immediate return to reset values; the user seed registers are also cleared.

Optional Feature:
TG_PRBS_ERR_INJ_EN
- Defined: adds inputs err_inj (1) and err_inj_bit (8). When err_inj is high on an accepted beat, dout[err_inj_bit] is inverted for that beat only. LFSR state is not affected, so a rewind replays clean data. The inversion is applied at the output register, so latency is unchanged.
- Undefined: the ports are absent and dout is always pure PRBS.

Decomposition:
- Package ddr4_v2_2_24_tg_prbs_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - tap-mask constants for PRBS 8/10/23;
  - function prbs_next(width, value);
  - function seed_sanitise.
- Sub-module ddr4_v2_2_24_tg_prbs_lfsr: one LFSR with load/step/restore controls and its snapshot register, instantiated DATA_WIDTH times in a generate loop.

Test Plan:
- PRBS_WIDTH=8, DATA_WIDTH=8, default seed bit0=8'hAA, burst_len=3, dout_ready=1 -> dout[0] = 1,0,1 on cycles N+2..N+4, done pulse at N+5, busy low at N+6.
- Backpressure: hold dout_ready=0 for 5 cycles mid-burst -> dout stable, beat_cnt frozen; total beats = burst_len, no duplicates or skips.
- User seed: write idx 3 = 0, use_user_seed=1, start -> lfsr[3] loads 1 (sanitised); write idx 200 -> no register changes; write in RUN -> ignored.
- Rewind: burst_len=4, capture beats; pulse rewind after beat 2 -> the next 4 beats equal the first 4, and done fires once, after the replayed 4th beat.
- burst_len=0 -> LOAD then DONE; dout_valid never asserted, done pulses at N+2.
- rst_n low mid-RUN -> all outputs 0 asynchronously; after release, start with use_user_seed=1 loads the sanitised value 1 into every LFSR.

Source files
------------

// File: rtl/ddr4_v2_2_24_tg_prbs_pkg.sv
// Shared types and PRBS helpers for the traffic-generator PRBS sequencer.
// The helpers work on a 23-bit container; callers pass the active LFSR length.
package ddr4_v2_2_24_tg_prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } prbs_state_e;

  localparam int PRBS_MAX_W = 23;

  localparam logic [PRBS_MAX_W-1:0] TAPS_PRBS8  = 23'h0000B8;  // bits 7,5,4,3
  localparam logic [PRBS_MAX_W-1:0] TAPS_PRBS10 = 23'h000240;  // bits 9,6
  localparam logic [PRBS_MAX_W-1:0] TAPS_PRBS23 = 23'h420000;  // bits 22,17

  function automatic logic [PRBS_MAX_W-1:0] width_mask(input int width);
    return (PRBS_MAX_W'(1) << width) - PRBS_MAX_W'(1);
  endfunction

  function automatic logic [PRBS_MAX_W-1:0] tap_mask(input int width);
    case (width)
      8:       return TAPS_PRBS8;
      10:      return TAPS_PRBS10;
      23:      return TAPS_PRBS23;
      default: return '0;
    endcase
  endfunction

  function automatic logic [PRBS_MAX_W-1:0] prbs_next(input int width,
                                                      input logic [PRBS_MAX_W-1:0] value);
    return {value[PRBS_MAX_W-2:0], ^(value & tap_mask(width))} & width_mask(width);
  endfunction

  function automatic logic [PRBS_MAX_W-1:0] seed_sanitise(input int width,
                                                          input logic [PRBS_MAX_W-1:0] seed);
    logic [PRBS_MAX_W-1:0] s;
    s = seed & width_mask(width);
    return (s == '0) ? PRBS_MAX_W'(1) : s;
  endfunction

endpackage

// File: rtl/ddr4_v2_2_24_tg_prbs_seq_ctrl_if.sv
// Control, seed-write and beat-stream bundle of the PRBS sequencer.
// TG_PRBS_ERR_INJ_EN adds the error-injection controls.
interface ddr4_v2_2_24_tg_prbs_seq_ctrl_if #(
  parameter int DATA_WIDTH  = 72,
  parameter int PRBS_WIDTH  = 23,
  parameter int BURST_CNT_W = 16
);
  logic                   use_user_seed;
  logic                   seed_wr_en;
  logic [7:0]             seed_wr_idx;
  logic [PRBS_WIDTH-1:0]  seed_wr_data;
  logic                   start;
  logic [BURST_CNT_W-1:0] burst_len;
  logic                   rewind;
  logic                   dout_valid;
  logic                   dout_ready;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   busy;
  logic                   done;
`ifdef TG_PRBS_ERR_INJ_EN
  logic                   err_inj;
  logic [7:0]             err_inj_bit;
`endif

  modport master (
`ifdef TG_PRBS_ERR_INJ_EN
    output err_inj, err_inj_bit,
`endif
    output use_user_seed, seed_wr_en, seed_wr_idx, seed_wr_data,
    output start, burst_len, rewind, dout_ready,
    input  dout_valid, dout, busy, done
  );

  modport slave (
`ifdef TG_PRBS_ERR_INJ_EN
    input  err_inj, err_inj_bit,
`endif
    input  use_user_seed, seed_wr_en, seed_wr_idx, seed_wr_data,
    input  start, burst_len, rewind, dout_ready,
    output dout_valid, dout, busy, done
  );

endinterface

// File: rtl/ddr4_v2_2_24_tg_prbs_lfsr.sv
// One Fibonacci PRBS lane: load from a (sanitised) seed, step, or restore the
// burst-start snapshot. Load has priority over restore, restore over step.
module ddr4_v2_2_24_tg_prbs_lfsr
  import ddr4_v2_2_24_tg_prbs_pkg::*;
#(
  parameter int PRBS_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  restore,
  input  logic                  step,
  input  logic [PRBS_WIDTH-1:0] seed,
  output logic                  msb
);

  logic [PRBS_WIDTH-1:0] lfsr_q;
  logic [PRBS_WIDTH-1:0] snap_q;
  logic [PRBS_WIDTH-1:0] seed_clean;
  logic [PRBS_WIDTH-1:0] lfsr_nxt;

  assign seed_clean = PRBS_WIDTH'(seed_sanitise(PRBS_WIDTH, PRBS_MAX_W'(seed)));
  assign lfsr_nxt   = PRBS_WIDTH'(prbs_next(PRBS_WIDTH, PRBS_MAX_W'(lfsr_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
      snap_q <= '0;
    end else if (load) begin
      lfsr_q <= seed_clean;
      snap_q <= seed_clean;
    end else if (restore) begin
      lfsr_q <= snap_q;
    end else if (step) begin
      lfsr_q <= lfsr_nxt;
    end
  end

  assign msb = lfsr_q[PRBS_WIDTH-1];

endmodule

// File: rtl/ddr4_v2_2_24_tg_prbs_seq_ctrl.sv
// PRBS burst sequencer: seeds, steps and rewinds one LFSR per DQ bit.
// Optional TG_PRBS_ERR_INJ_EN: single-bit error injection on accepted beats.
module ddr4_v2_2_24_tg_prbs_seq_ctrl
  import ddr4_v2_2_24_tg_prbs_pkg::*;
#(
  parameter int DATA_WIDTH  = 72,
  parameter int PRBS_WIDTH  = 23,
  parameter int BURST_CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*PRBS_WIDTH-1:0] default_seed,
  ddr4_v2_2_24_tg_prbs_seq_ctrl_if.slave   bus
);

  if (!(PRBS_WIDTH == 8 || PRBS_WIDTH == 10 || PRBS_WIDTH == 23)) begin : g_bad_prbs_width
    $error("PRBS_WIDTH must be 8, 10 or 23");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 144) begin : g_bad_data_width
    $error("DATA_WIDTH must be in 1..144");
  end

  prbs_state_e            state_q, state_d;
  logic [BURST_CNT_W-1:0] len_q;
  logic [BURST_CNT_W-1:0] beat_cnt_q;
  logic                   user_sel_q;
  logic                   have_burst_q;
  logic [PRBS_WIDTH-1:0]  user_seed_q [DATA_WIDTH];
  logic [DATA_WIDTH-1:0]  prbs_bits;
  logic                   ld, restore, step;
  logic                   accept, last_beat, seed_wr_ok;

  assign accept     = (state_q == RUN) && bus.dout_ready;
  assign last_beat  = (beat_cnt_q == len_q - BURST_CNT_W'(1));
  assign seed_wr_ok = bus.seed_wr_en && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Rewind outranks a beat accepted in the same cycle; start outranks rewind.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    restore = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
        end else if (bus.rewind && have_burst_q) begin
          restore = 1'b1;
          state_d = (len_q == '0) ? DONE : RUN;
        end
      end
      LOAD: begin
        ld      = 1'b1;
        state_d = (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (bus.rewind) begin
          restore = 1'b1;
        end else if (accept) begin
          step = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      user_sel_q   <= 1'b0;
      have_burst_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        len_q      <= bus.burst_len;
        user_sel_q <= bus.use_user_seed;
      end
      if (ld) have_burst_q <= 1'b1;
      if (ld || restore) beat_cnt_q <= '0;
      else if (step)     beat_cnt_q <= beat_cnt_q + BURST_CNT_W'(1);
    end
  end

  // Out-of-range indices match no lane and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_WIDTH; i++) user_seed_q[i] <= '0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++)
        if (seed_wr_ok && bus.seed_wr_idx == 8'(i)) user_seed_q[i] <= bus.seed_wr_data;
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    logic [PRBS_WIDTH-1:0] seed_sel;
    assign seed_sel = user_sel_q ? user_seed_q[i]
                                 : default_seed[i*PRBS_WIDTH +: PRBS_WIDTH];
    ddr4_v2_2_24_tg_prbs_lfsr #(.PRBS_WIDTH(PRBS_WIDTH)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ld),
      .restore (restore),
      .step    (step),
      .seed    (seed_sel),
      .msb     (prbs_bits[i])
    );
  end

  assign bus.dout_valid = (state_q == RUN);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

`ifdef TG_PRBS_ERR_INJ_EN
  logic [DATA_WIDTH-1:0] inj_mask;
  always_comb begin
    inj_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (bus.err_inj && accept && bus.err_inj_bit == 8'(i)) inj_mask[i] = 1'b1;
  end
  assign bus.dout = prbs_bits ^ inj_mask;
`else
  assign bus.dout = prbs_bits;
`endif

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_prbs_seq_ctrl.sv
// Directed bench for the PRBS sequencer: 8 lanes of PRBS8, hand-computed
// vectors plus an independent 8-bit LFSR model for longer bursts.
module tb_ddr4_v2_2_24_tg_prbs_seq_ctrl;

  localparam int DW = 8;
  localparam int PW = 8;
  localparam int BW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW*PW-1:0] default_seed;

  ddr4_v2_2_24_tg_prbs_seq_ctrl_if #(.DATA_WIDTH(DW), .PRBS_WIDTH(PW), .BURST_CNT_W(BW)) bus_if ();

  ddr4_v2_2_24_tg_prbs_seq_ctrl #(.DATA_WIDTH(DW), .PRBS_WIDTH(PW), .BURST_CNT_W(BW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .default_seed (default_seed),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        use_user;
    logic [15:0] len;
    logic [15:0] ready_pat;
    logic [7:0]  exp_first;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] dseed  [DW];
  logic [7:0] m_user [DW];
  logic [7:0] m_lfsr [DW];
  logic [7:0] m_snap [DW];
  logic [7:0] cap    [4];
  vec_t       vecs   [4];

  function automatic logic [7:0] m_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] m_clean(input logic [7:0] v);
    return (v == 8'h00) ? 8'h01 : v;
  endfunction

  function automatic logic [DW-1:0] m_dout();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = m_lfsr[i][7];
    return r;
  endfunction

  task automatic m_load(input logic user);
    for (int i = 0; i < DW; i++) m_lfsr[i] = m_clean(user ? m_user[i] : dseed[i]);
    m_snap = m_lfsr;
  endtask

  task automatic m_step();
    for (int i = 0; i < DW; i++) m_lfsr[i] = m_next(m_lfsr[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_seed(input logic [7:0] idx, input logic [7:0] data);
    bus_if.seed_wr_en   = 1'b1;
    bus_if.seed_wr_idx  = idx;
    bus_if.seed_wr_data = data;
    tick();
    bus_if.seed_wr_en = 1'b0;
    if (int'(idx) < DW) m_user[idx[2:0]] = data;
  endtask

  task automatic run_burst(input logic user, input logic [15:0] len, input logic [15:0] pat,
                           input logic [7:0] exp_first, input string tag);
    int beats = 0;
    int cyc   = 0;
    bus_if.use_user_seed = user;
    bus_if.burst_len     = len;
    bus_if.start         = 1'b1;
    tick();
    bus_if.start         = 1'b0;
    bus_if.use_user_seed = 1'b0;
    check({tag, "_load_busy"}, 32'(bus_if.busy), 32'd1);
    check({tag, "_load_valid"}, 32'(bus_if.dout_valid), 32'd0);
    m_load(user);
    tick();
    while (beats < int'(len) && cyc < 300) begin
      check({tag, "_valid"}, 32'(bus_if.dout_valid), 32'd1);
      check({tag, "_dout"}, 32'(bus_if.dout), 32'(m_dout()));
      if (cyc == 0) check({tag, "_first"}, 32'(bus_if.dout), 32'(exp_first));
      bus_if.dout_ready = pat[cyc % 16];
      if (pat[cyc % 16]) begin
        m_step();
        beats++;
      end
      tick();
      cyc++;
    end
    bus_if.dout_ready = 1'b0;
    check({tag, "_beats"}, 32'(beats), 32'(len));
    check({tag, "_done"}, 32'(bus_if.done), 32'd1);
    check({tag, "_done_valid"}, 32'(bus_if.dout_valid), 32'd0);
    tick();
    check({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, "_idle_done"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    dseed  = '{8'hAA, 8'h35, 8'hC3, 8'h5A, 8'h80, 8'h01, 8'hFF, 8'h00};
    m_user = '{default: 8'h00};
    for (int i = 0; i < DW; i++) default_seed[i*PW +: PW] = dseed[i];
    vecs[0] = '{1'b0, 16'd6, 16'hFE0F, 8'h55};
    vecs[1] = '{1'b1, 16'd9, 16'hAAAA, 8'hA5};
    vecs[2] = '{1'b0, 16'd1, 16'hFFFF, 8'h55};
    vecs[3] = '{1'b1, 16'd2, 16'h5555, 8'hA5};

    rst_n = 1'b0;
    bus_if.use_user_seed = 1'b0;
    bus_if.seed_wr_en    = 1'b0;
    bus_if.seed_wr_idx   = 8'd0;
    bus_if.seed_wr_data  = 8'd0;
    bus_if.start         = 1'b0;
    bus_if.burst_len     = '0;
    bus_if.rewind        = 1'b0;
    bus_if.dout_ready    = 1'b0;
`ifdef TG_PRBS_ERR_INJ_EN
    bus_if.err_inj       = 1'b0;
    bus_if.err_inj_bit   = 8'd0;
`endif
    tick();
    tick();
    check("rst_valid", 32'(bus_if.dout_valid), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_dout", 32'(bus_if.dout), 32'd0);
    rst_n = 1'b1;
    tick();

    // Rewind before any burst has nothing to replay.
    bus_if.rewind = 1'b1;
    tick();
    bus_if.rewind = 1'b0;
    check("rw_noburst_busy", 32'(bus_if.busy), 32'd0);

    // Latency and first sequence, fully hand-computed (dout[0] = 1,0,1).
    bus_if.burst_len = 16'd3;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("lat_load_busy", 32'(bus_if.busy), 32'd1);
    check("lat_load_valid", 32'(bus_if.dout_valid), 32'd0);
    tick();
    bus_if.dout_ready = 1'b1;
    check("lat_b0_valid", 32'(bus_if.dout_valid), 32'd1);
    check("lat_b0", 32'(bus_if.dout), 32'h55);
    tick();
    check("lat_b1", 32'(bus_if.dout), 32'h4C);
    tick();
    check("lat_b2", 32'(bus_if.dout), 32'h43);
    tick();
    bus_if.dout_ready = 1'b0;
    check("lat_done", 32'(bus_if.done), 32'd1);
    check("lat_done_valid", 32'(bus_if.dout_valid), 32'd0);
    tick();
    check("lat_idle_busy", 32'(bus_if.busy), 32'd0);
    check("lat_idle_done", 32'(bus_if.done), 32'd0);

    // User seeds; idx 3 zero is sanitised, idx 200 must not alias onto a lane.
    write_seed(8'd0, 8'h80);
    write_seed(8'd1, 8'h12);
    write_seed(8'd2, 8'hF0);
    write_seed(8'd3, 8'h00);
    write_seed(8'd4, 8'h7F);
    write_seed(8'd5, 8'h81);
    write_seed(8'd6, 8'h40);
    write_seed(8'd7, 8'hC0);
    write_seed(8'd200, 8'h00);

    for (int v = 0; v < 4; v++)
      run_burst(vecs[v].use_user, vecs[v].len, vecs[v].ready_pat, vecs[v].exp_first,
                $sformatf("vec%0d", v));

    // Seed write during RUN is dropped.
    bus_if.use_user_seed = 1'b1;
    bus_if.burst_len     = 16'd2;
    bus_if.start         = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    bus_if.seed_wr_en   = 1'b1;
    bus_if.seed_wr_idx  = 8'd0;
    bus_if.seed_wr_data = 8'h00;
    bus_if.dout_ready   = 1'b1;
    tick();
    bus_if.seed_wr_en = 1'b0;
    tick();
    bus_if.dout_ready = 1'b0;
    check("runwr_done", 32'(bus_if.done), 32'd1);
    tick();
    run_burst(1'b1, 16'd1, 16'hFFFF, 8'hA5, "runwr_after");

    // Seed write in the same cycle as start is seen by LOAD.
    bus_if.seed_wr_en   = 1'b1;
    bus_if.seed_wr_idx  = 8'd2;
    bus_if.seed_wr_data = 8'h0F;
    m_user[2] = 8'h0F;
    run_burst(1'b1, 16'd1, 16'hFFFF, 8'hA1, "wr_start");
    bus_if.seed_wr_en = 1'b0;

    // Zero-length burst: LOAD then DONE, no valid beat.
    bus_if.burst_len = 16'd0;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("len0_load_valid", 32'(bus_if.dout_valid), 32'd0);
    check("len0_load_busy", 32'(bus_if.busy), 32'd1);
    tick();
    check("len0_done", 32'(bus_if.done), 32'd1);
    check("len0_done_valid", 32'(bus_if.dout_valid), 32'd0);
    tick();
    check("len0_idle_busy", 32'(bus_if.busy), 32'd0);

    // Rewind colliding with beat 2 replays from beat 0; done fires once.
    done_cnt = 0;
    bus_if.burst_len = 16'd4;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    m_load(1'b0);
    tick();
    bus_if.dout_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      cap[b] = bus_if.dout;
      check("rw_pass1", 32'(bus_if.dout), 32'(m_dout()));
      if (b == 2) begin
        bus_if.rewind = 1'b1;
        m_lfsr = m_snap;
      end else begin
        m_step();
      end
      tick();
      if (bus_if.done) done_cnt++;
    end
    bus_if.rewind = 1'b0;
    check("rw_replay0", 32'(bus_if.dout), 32'(cap[0]));
    for (int b = 0; b < 4; b++) begin
      check("rw_replay_valid", 32'(bus_if.dout_valid), 32'd1);
      check("rw_replay", 32'(bus_if.dout), 32'(m_dout()));
      if (b < 3) check("rw_replay_cap", 32'(bus_if.dout), 32'(cap[b]));
      m_step();
      tick();
      if (bus_if.done) done_cnt++;
    end
    bus_if.dout_ready = 1'b0;
    check("rw_done_now", 32'(bus_if.done), 32'd1);
    tick();
    check("rw_done_once", 32'(done_cnt), 32'd1);
    check("rw_idle_busy", 32'(bus_if.busy), 32'd0);

    // Rewind from IDLE replays the last burst.
    bus_if.rewind = 1'b1;
    tick();
    bus_if.rewind = 1'b0;
    m_lfsr = m_snap;
    check("rwi_valid", 32'(bus_if.dout_valid), 32'd1);
    check("rwi_b0", 32'(bus_if.dout), 32'(cap[0]));
    bus_if.dout_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check("rwi_dout", 32'(bus_if.dout), 32'(m_dout()));
      m_step();
      tick();
    end
    bus_if.dout_ready = 1'b0;
    check("rwi_done", 32'(bus_if.done), 32'd1);
    tick();

    // Asynchronous reset mid-RUN also clears the user seed registers.
    bus_if.burst_len = 16'd10;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    bus_if.dout_ready = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus_if.dout_valid), 32'd0);
    check("arst_busy", 32'(bus_if.busy), 32'd0);
    check("arst_done", 32'(bus_if.done), 32'd0);
    check("arst_dout", 32'(bus_if.dout), 32'd0);
    bus_if.dout_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    m_user = '{default: 8'h00};
    tick();
    run_burst(1'b1, 16'd9, 16'hFFFF, 8'h00, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
